// File: rtl/dsp_mac_scheduler.sv
// Round-robin scheduler sharing one QL_DSPV2 MAC between NREQ dot-product requester streams.
// Optional build macro DSP_SCHED_TIMEOUT_EN aborts a job whose requester stalls for TIMEOUT cycles.
module dsp_mac_scheduler #(
  parameter int NREQ    = 4,
  parameter int DSP_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ-1:0]          req_last_i,
  input  logic [NREQ*20-1:0]       req_a_i,
  input  logic [NREQ*18-1:0]       req_b_i,
  output logic [19:0]              dsp_a_o,
  output logic [17:0]              dsp_b_o,
  output logic                     dsp_load_acc_o,
  output logic                     dsp_acc_reset_o,
  output logic [2:0]               dsp_feedback_o,
  output logic [2:0]               dsp_output_select_o,
  input  logic [37:0]              dsp_z_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [37:0]              res_z_o,
  output logic [$clog2(NREQ)-1:0]  res_id_o,
  output logic                     res_err_o
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);
  localparam logic [2:0]     LAT_W   = 3'(DSP_LAT);

  if (NREQ < 2 || NREQ > 8 || DSP_LAT < 1 || DSP_LAT > 4 || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_param_check
    $error("dsp_mac_scheduler: parameter out of range");
  end

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [19:0]    dsp_a_q, dsp_a_d;
  logic [17:0]    dsp_b_q, dsp_b_d;
  logic           dsp_load_acc_q, dsp_load_acc_d;
  logic           dsp_acc_reset_q, dsp_acc_reset_d;
  logic           res_valid_q, res_valid_d;
  logic [37:0]    res_z_q, res_z_d;
  logic [IDW-1:0] res_id_q, res_id_d;
`ifdef DSP_SCHED_TIMEOUT_EN
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  logic [15:0]    stall_q, stall_d;
  logic           res_err_q, res_err_d;
`endif

  logic [19:0]    a_arr [NREQ];
  logic [17:0]    b_arr [NREQ];
  logic           sel_found, in_idle, grant_act, beat_acc, beat_last;
  logic [IDW-1:0] sel_id, cur_id;
  logic [IDW:0]   cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a_i[20*gi +: 20];
    assign b_arr[gi] = req_b_i[18*gi +: 18];
  end

  // Search starts at rr_ptr and wraps, so the last served requester is checked last.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!sel_found && req_valid_i[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  assign in_idle   = (state_q == S_IDLE);
  assign cur_id    = in_idle ? sel_id : gnt_id_q;
  // Ready is combinational in IDLE; gating with rst_ni keeps it low throughout reset.
  assign grant_act = rst_ni && ((in_idle && sel_found) || (state_q == S_RUN));
  assign beat_acc  = grant_act && req_valid_i[cur_id];
  assign beat_last = req_last_i[cur_id];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready_o[gi] = grant_act && (cur_id == IDW'(gi));
  end

  always_comb begin
    state_d         = state_q;
    gnt_id_d        = gnt_id_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    dsp_a_d         = dsp_a_q;
    dsp_b_d         = dsp_b_q;
    dsp_load_acc_d  = beat_acc;
    dsp_acc_reset_d = beat_acc && in_idle;
    res_valid_d     = res_valid_q;
    res_z_d         = res_z_q;
    res_id_d        = res_id_q;
`ifdef DSP_SCHED_TIMEOUT_EN
    stall_d         = '0;
    res_err_d       = res_err_q;
`endif
    if (beat_acc) begin
      dsp_a_d = a_arr[cur_id];
      dsp_b_d = b_arr[cur_id];
    end
    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          gnt_id_d = sel_id;
          state_d  = S_RUN;
          if (beat_last) begin
            state_d = S_DRAIN;
            cnt_d   = LAT_W;
          end
        end
      end
      S_RUN: begin
        if (beat_acc) begin
          if (beat_last) begin
            state_d = S_DRAIN;
            cnt_d   = LAT_W;
          end
        end
`ifdef DSP_SCHED_TIMEOUT_EN
        else if (stall_q == TO_M1) begin
          state_d         = S_RESP;
          dsp_acc_reset_d = 1'b1;
          res_valid_d     = 1'b1;
          res_err_d       = 1'b1;
          res_z_d         = '0;
          res_id_d        = gnt_id_q;
        end else begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end
      S_DRAIN: begin
        if (cnt_q == 3'd0) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_z_d     = dsp_z_i;
          res_id_d    = gnt_id_q;
`ifdef DSP_SCHED_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (res_ready_i) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          rr_ptr_d    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
`ifdef DSP_SCHED_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      gnt_id_q        <= '0;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      dsp_a_q         <= '0;
      dsp_b_q         <= '0;
      dsp_load_acc_q  <= 1'b0;
      dsp_acc_reset_q <= 1'b0;
      res_valid_q     <= 1'b0;
      res_z_q         <= '0;
      res_id_q        <= '0;
`ifdef DSP_SCHED_TIMEOUT_EN
      stall_q         <= '0;
      res_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      gnt_id_q        <= gnt_id_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      dsp_a_q         <= dsp_a_d;
      dsp_b_q         <= dsp_b_d;
      dsp_load_acc_q  <= dsp_load_acc_d;
      dsp_acc_reset_q <= dsp_acc_reset_d;
      res_valid_q     <= res_valid_d;
      res_z_q         <= res_z_d;
      res_id_q        <= res_id_d;
`ifdef DSP_SCHED_TIMEOUT_EN
      stall_q         <= stall_d;
      res_err_q       <= res_err_d;
`endif
    end
  end

  assign dsp_a_o             = dsp_a_q;
  assign dsp_b_o             = dsp_b_q;
  assign dsp_load_acc_o      = dsp_load_acc_q;
  assign dsp_acc_reset_o     = dsp_acc_reset_q;
  assign dsp_feedback_o      = 3'b000;
  assign dsp_output_select_o = 3'b001;
  assign res_valid_o         = res_valid_q;
  assign res_z_o             = res_z_q;
  assign res_id_o            = res_id_q;
`ifdef DSP_SCHED_TIMEOUT_EN
  assign res_err_o           = res_err_q;
`else
  assign res_err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_scheduler.sv
// Directed bench for dsp_mac_scheduler with a behavioural single-stage DSP accumulator.
module tb_dsp_mac_scheduler;
  localparam int NREQ = 4;
  localparam int LAT  = 1;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ*20-1:0] req_a = '0;
  logic [NREQ*18-1:0] req_b = '0;
  logic [19:0]       dsp_a;
  logic [17:0]       dsp_b;
  logic              dsp_load_acc, dsp_acc_reset;
  logic [2:0]        dsp_feedback, dsp_output_select;
  logic [37:0]       dsp_z;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [37:0]       res_z;
  logic [1:0]        res_id;
  logic              res_err;

  dsp_mac_scheduler #(.NREQ(NREQ), .DSP_LAT(LAT), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_last_i(req_last),
    .req_a_i(req_a), .req_b_i(req_b),
    .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_load_acc_o(dsp_load_acc),
    .dsp_acc_reset_o(dsp_acc_reset), .dsp_feedback_o(dsp_feedback),
    .dsp_output_select_o(dsp_output_select), .dsp_z_i(dsp_z),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_z_o(res_z),
    .res_id_o(res_id), .res_err_o(res_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DSP accumulator model: not cleared by the scheduler reset, so stale sums must be dropped by acc_reset.
  logic signed [37:0] acc = '0;
  logic signed [37:0] prod;
  assign prod = $signed(dsp_a) * $signed(dsp_b);
  always @(posedge clk) if (dsp_load_acc) acc <= (dsp_acc_reset ? 38'sd0 : acc) + prod;
  assign dsp_z = acc;

  int n_chk = 0;
  int n_fail = 0;
  int acc_edge = 0;
  int res_edge = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic raise(input int r, input int a, input int b, input bit last);
    req_valid[r] = 1'b1;
    req_last[r]  = last;
    req_a[20*r +: 20] = 20'(a);
    req_b[18*r +: 18] = 18'(b);
  endtask

  task automatic take(input int r);
    @(negedge clk);
    acc_edge     = cyc;
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic send_beat(input int r, input int a, input int b, input bit last,
                           input bit first, input string nm);
    int w;
    logic [19:0] ea;
    w  = 0;
    ea = 20'(a);
    raise(r, a, b, last);
    #1;
    while (req_ready[r] !== 1'b1 && w < 40) begin
      @(negedge clk); #1; w++;
    end
    if (req_ready[r] !== 1'b1) chk({nm, " ready timeout"}, 64'(req_ready[r]), 64'd1);
    take(r);
    chk({nm, " load_acc"}, 64'(dsp_load_acc), 64'd1);
    chk({nm, " acc_reset"}, 64'(dsp_acc_reset), 64'(first));
    chk({nm, " dsp_a"}, 64'(dsp_a), 64'(ea));
  endtask

  task automatic wait_valid(input string nm);
    int w;
    w = 0;
    while (res_valid !== 1'b1 && w < 40) begin
      @(negedge clk); w++;
    end
    res_edge = cyc;
    if (res_valid !== 1'b1) chk({nm, " res_valid timeout"}, 64'(res_valid), 64'd1);
  endtask

  task automatic check_res(input string nm, input longint z, input int id);
    logic [37:0] ez;
    logic [1:0]  eid;
    ez  = 38'(z);
    eid = 2'(id);
    wait_valid(nm);
    chk({nm, " res_z"}, 64'(res_z), 64'(ez));
    chk({nm, " res_id"}, 64'(res_id), 64'(eid));
    chk({nm, " res_err"}, 64'(res_err), 64'd0);
    chk({nm, " latency"}, 64'(res_edge - acc_edge), 64'(LAT + 1));
    $display("result %s: id=%0d z=%0d err=%0b latency=%0d", nm, res_id, $signed(res_z),
             res_err, res_edge - acc_edge);
  endtask

  task automatic accept_res(input string nm);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, " res_valid clear"}, 64'(res_valid), 64'd0);
  endtask

  typedef struct {
    int     id;
    int     n;
    int     a[4];
    int     b[4];
    longint ez;
  } job_t;

  job_t jobs[5];

  initial begin
    bit ok;
    jobs[0] = '{0, 3, '{3, 5, 2, 0}, '{4, 6, 10, 0}, 64'sd62};
    jobs[1] = '{2, 1, '{-7, 0, 0, 0}, '{9, 0, 0, 0}, -64'sd63};
    jobs[2] = '{1, 2, '{-524288, -524288, 0, 0}, '{-131072, -131072, 0, 0}, -64'sd137438953472};
    jobs[3] = '{0, 4, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 64'sd30};
    jobs[4] = '{3, 2, '{-100, 50, 0, 0}, '{200, -3, 0, 0}, -64'sd20150};

    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset dsp_a", 64'(dsp_a), 64'd0);
    chk("reset dsp_b", 64'(dsp_b), 64'd0);
    chk("reset load_acc", 64'(dsp_load_acc), 64'd0);
    chk("reset acc_reset", 64'(dsp_acc_reset), 64'd0);
    chk("reset res_valid", 64'(res_valid), 64'd0);
    chk("reset res_z", 64'(res_z), 64'd0);
    chk("reset res_id", 64'(res_id), 64'd0);
    chk("reset res_err", 64'(res_err), 64'd0);
    chk("feedback const", 64'(dsp_feedback), 64'd0);
    chk("output_select const", 64'(dsp_output_select), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < jobs[j].n; k++)
        send_beat(jobs[j].id, jobs[j].a[k], jobs[j].b[k], k == jobs[j].n - 1, k == 0,
                  $sformatf("job%0d beat%0d", j, k));
      check_res($sformatf("job%0d", j), jobs[j].ez, jobs[j].id);
      accept_res($sformatf("job%0d", j));
    end

    // Contention with rr_ptr at 0: requesters 1 and 2 together, then 3 and 1 queue up.
    raise(1, 6, 7, 1'b1);
    raise(2, -3, 11, 1'b1);
    #1 chk("contention grant r1", 64'(req_ready), 64'b0010);
    take(1);
    check_res("cont r1", 64'sd42, 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_z !== 38'd42 || res_id !== 2'd1 || req_ready !== 4'b0000 ||
          dsp_load_acc !== 1'b0 || dsp_acc_reset !== 1'b0) ok = 1'b0;
    end
    chk("backpressure hold", 64'(ok), 64'd1);
    accept_res("cont r1");
    chk("grant r2 after r1", 64'(req_ready), 64'b0100);
    raise(3, 2, 5, 1'b1);
    raise(1, 4, 4, 1'b1);
    #1 chk("grant persists r2", 64'(req_ready), 64'b0100);
    take(2);
    check_res("cont r2", -64'sd33, 2);
    accept_res("cont r2");
    chk("r3 before r1", 64'(req_ready), 64'b1000);
    take(3);
    check_res("cont r3", 64'sd10, 3);
    accept_res("cont r3");
    chk("r1 after r3", 64'(req_ready), 64'b0010);
    take(1);
    check_res("cont r1 again", 64'sd16, 1);
    accept_res("cont r1 again");

    // Mid-job stall on requester 2 while requester 0 waits.
    send_beat(2, 10, 10, 1'b0, 1'b1, "stall b0");
    raise(0, 1, 1, 1'b1);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (dsp_load_acc !== 1'b0 || req_ready !== 4'b0100) ok = 1'b0;
    end
    chk("stall hold", 64'(ok), 64'd1);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    send_beat(2, -4, 5, 1'b0, 1'b0, "stall b1");
    send_beat(2, 7, 1, 1'b1, 1'b0, "stall b2");
    check_res("stall job", 64'sd87, 2);
    accept_res("stall job");

    // Asynchronous reset in the middle of a job from requester 3.
    send_beat(3, 100, 100, 1'b0, 1'b1, "rst b0");
    raise(3, 1, 1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req_ready", 64'(req_ready), 64'd0);
    chk("midrst dsp_a", 64'(dsp_a), 64'd0);
    chk("midrst dsp_b", 64'(dsp_b), 64'd0);
    chk("midrst load_acc", 64'(dsp_load_acc), 64'd0);
    chk("midrst acc_reset", 64'(dsp_acc_reset), 64'd0);
    chk("midrst res_valid", 64'(res_valid), 64'd0);
    chk("midrst res_z", 64'(res_z), 64'd0);
    chk("midrst res_id", 64'(res_id), 64'd0);
    @(negedge clk);
    @(negedge clk);
    req_valid[3] = 1'b0;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (res_valid !== 1'b0) ok = 1'b0;
    end
    chk("no stale result", 64'(ok), 64'd1);
    send_beat(0, 5, 5, 1'b1, 1'b1, "post-rst b0");
    check_res("post-rst job", 64'sd25, 0);
    accept_res("post-rst job");

`ifdef DSP_SCHED_TIMEOUT_EN
    send_beat(1, 2, 3, 1'b0, 1'b1, "tmo b0");
    send_beat(1, 4, 5, 1'b0, 1'b0, "tmo b1");
    raise(2, 3, 3, 1'b1);
    wait_valid("timeout");
    chk("timeout res_err", 64'(res_err), 64'd1);
    chk("timeout res_z", 64'(res_z), 64'd0);
    chk("timeout res_id", 64'(res_id), 64'd1);
    chk("timeout req_ready", 64'(req_ready), 64'd0);
    $display("result timeout: id=%0d z=%0d err=%0b", res_id, $signed(res_z), res_err);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("timeout err clear", 64'(res_err), 64'd0);
    chk("grant r2 after timeout", 64'(req_ready), 64'b0100);
    take(2);
    check_res("after timeout", 64'sd9, 2);
    accept_res("after timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
